// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the double-buffered Game Boy
// framebuffer arbiter (160x144 pixels, 2 bpp, two banks in one RAM).
package fb_pkg;

  localparam int unsigned FB_WIDTH   = 160;
  localparam int unsigned FB_HEIGHT  = 144;
  localparam int unsigned FB_DEPTH   = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned PIX_W      = 2;
  localparam int unsigned RAM_ADDR_W = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0]  pixel_t;

  // One buffered PPU pixel write.
  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } fb_wr_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: small synchronous FIFO buffering PPU pixel writes.
// Ports:
//   clk, rst       clock, asynchronous active-low reset (flushes contents)
//   push/push_data enqueue one entry; ignored while full
//   pop/pop_data   dequeue head entry; ignored while empty; pop_data shows head
//   full, empty    occupancy flags derived from wrap-bit pointers
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  fb_wr_t push_data,
  input  logic   pop,
  output fb_wr_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  fb_wr_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Same index with differing wrap bits means the FIFO has lapped itself.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rptr[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between scanout reads,
// buffered PPU writes and a bulk clear engine, and swaps front/back banks
// only when the back bank holds a complete frame.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data PPU pixel writes into the back bank
//   rd_req/rd_addr -> rd_valid/rd_data scanout reads from the front bank (2-cycle)
//   clr_start/clr_color -> clr_busy/clr_done  back-bank fill engine
//   frame_end, vblank -> bank, swap  bank swap sequencing
//   ram_addr/ram_din/ram_we, ram_dout RAM port ({bank, pixel} addressing)
module fb_arbiter #(
  parameter int unsigned FB_DEPTH   = fb_pkg::FB_DEPTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_addr,
  input  logic [1:0]  wr_data,
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic        rd_valid,
  output logic [1:0]  rd_data,
  input  logic        clr_start,
  input  logic [1:0]  clr_color,
  output logic        clr_busy,
  output logic        clr_done,
  input  logic        frame_end,
  input  logic        vblank,
  output logic        bank,
  output logic        swap,
  output logic [15:0] ram_addr,
  output logic [1:0]  ram_din,
  output logic        ram_we,
  input  logic [1:0]  ram_dout
);

  import fb_pkg::*;

  localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_DEPTH - 1);

  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  fb_wr_t     fifo_in;
  fb_wr_t     fifo_out;

  clr_state_t clr_state;
  clr_state_t clr_state_nxt;
  fb_addr_t   clr_cnt;
  fb_addr_t   clr_cnt_nxt;
  pixel_t     clr_col;
  pixel_t     clr_col_nxt;
  logic       clr_done_nxt;

  logic       rd_gnt;
  logic       clr_gnt;
  logic       wr_gnt;
  logic       rd_pend;
  logic       swap_pending;

  // Fixed priority: read > clear > FIFO write. FIFO drains only once a clear is over.
  assign rd_gnt   = rd_req;
  assign clr_gnt  = ~rd_req & clr_busy;
  assign wr_gnt   = ~rd_req & ~clr_busy & ~fifo_empty;

  assign wr_ready = ~fifo_full;
  assign push     = wr_valid & ~fifo_full;
  assign pop      = wr_gnt;
  assign fifo_in  = '{addr: wr_addr, data: wr_data};

  assign clr_busy = (clr_state == C_RUN);

  // Swap only when the back bank can no longer change under the scanout.
  assign swap     = swap_pending & vblank & fifo_empty & ~clr_busy;

  // RAM data arrives the cycle rd_valid is high; pass it straight through.
  assign rd_data  = rd_valid ? ram_dout : 2'b00;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Clear FSM next-state.
  always_comb begin
    clr_state_nxt = clr_state;
    clr_cnt_nxt   = clr_cnt;
    clr_col_nxt   = clr_col;
    clr_done_nxt  = 1'b0;
    case (clr_state)
      C_IDLE: begin
        if (clr_start) begin
          clr_state_nxt = C_RUN;
          clr_cnt_nxt   = '0;
          clr_col_nxt   = clr_color;
        end
      end
      C_RUN: begin
        if (clr_gnt) begin
          if (clr_cnt == CLR_LAST) begin
            clr_state_nxt = C_IDLE;
            clr_done_nxt  = 1'b1;
          end else begin
            clr_cnt_nxt = clr_cnt + fb_addr_t'(1);
          end
        end
      end
      default: clr_state_nxt = C_IDLE;
    endcase
  end

  // Clear FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_state <= C_IDLE;
      clr_cnt   <= '0;
      clr_col   <= '0;
      clr_done  <= 1'b0;
    end else begin
      clr_state <= clr_state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      clr_col   <= clr_col_nxt;
      clr_done  <= clr_done_nxt;
    end
  end

  // RAM port and read-return pipeline; a read's bank is captured at its grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_pend  <= rd_gnt;
      rd_valid <= rd_pend;
      ram_we   <= clr_gnt | wr_gnt;
      if (rd_gnt) begin
        ram_addr <= {bank, rd_addr};
      end else if (clr_gnt) begin
        ram_addr <= {~bank, clr_cnt};
        ram_din  <= clr_col;
      end else if (wr_gnt) begin
        ram_addr <= {~bank, fifo_out.addr};
        ram_din  <= fifo_out.data;
      end
    end
  end

  // Bank swap bookkeeping; extra frame_end pulses while pending collapse into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank         <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap) begin
      bank         <= ~bank;
      swap_pending <= 1'b0;
    end else if (frame_end) begin
      swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed stimulus with a queue scoreboard for fb_arbiter.
// Stimulus pushes expected RAM writes and read returns; a negedge monitor
// pops and compares whenever the DUT shows ram_we or rd_valid.
module tb_fb_arbiter;

  localparam int FB      = 23040;
  localparam int CLR_CYC = 2 * FB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [14:0] wr_addr = '0;
  logic [1:0]  wr_data = '0;
  logic        rd_req = 1'b0;
  logic [14:0] rd_addr = '0;
  logic        rd_valid;
  logic [1:0]  rd_data;
  logic        clr_start = 1'b0;
  logic [1:0]  clr_color = '0;
  logic        clr_busy;
  logic        clr_done;
  logic        frame_end = 1'b0;
  logic        vblank = 1'b0;
  logic        bank;
  logic        swap;
  logic [15:0] ram_addr;
  logic [1:0]  ram_din;
  logic        ram_we;
  logic [1:0]  ram_dout;

  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [1:0]  pl_data = '0;
  logic [1:0]  mem [65536];

  logic [17:0] exp_wr [$];
  logic [1:0]  exp_rd [$];
  logic [17:0] e_w;
  logic [1:0]  e_r;
  int          total = 0;
  int          bad = 0;
  int          swap_cnt = 0;
  int          s0;

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .frame_end (frame_end),
    .vblank    (vblank),
    .bank      (bank),
    .swap      (swap),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  // Single-port RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every RAM write and read return against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=%0h exp=none", {ram_addr, ram_din});
        end else begin
          e_w = exp_wr.pop_front();
          chk("ram_write", 32'({ram_addr, ram_din}), 32'(e_w));
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read got=%0h exp=none", rd_data);
        end else begin
          e_r = exp_rd.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e_r));
        end
      end
      if (swap) swap_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with RAM preload of {0,5} = 2'b10.
    pl_we = 1'b1; pl_addr = 16'h0005; pl_data = 2'b10;
    next_cyc();
    pl_we = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data",  32'(rd_data), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    chk("rst_bank",     32'(bank), 0);
    chk("rst_swap",     32'(swap), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din",  32'(ram_din), 0);
    chk("rst_ram_we",   32'(ram_we), 0);
    next_cyc();
    rst = 1'b1;

    // Continuous reads; a pending FIFO write waits until reads stop.
    wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 2'd3;
    exp_wr.push_back({1'b1, 15'd7, 2'd3});
    for (int c = 0; c < 10; c++) begin
      rd_req = (c < 6); rd_addr = 15'd5;
      if (c < 6) exp_rd.push_back(2'b10);
      if (c >= 1) wr_valid = 1'b0;
      @(negedge clk);
      if (c == 1) chk("rd_lat1", 32'(rd_valid), 0);
      if (c == 1) chk("wr_ready_one_entry", 32'(wr_ready), 1);
      if (c == 2) chk("rd_lat2", 32'(rd_valid), 1);
      if (c == 5) chk("no_write_during_reads", 32'(ram_we), 0);
      if (c == 7) chk("write_after_reads", 32'(ram_we), 1);
      next_cyc();
    end
    chk("p1_wr_drained", 32'(exp_wr.size()), 0);
    chk("p1_rd_drained", 32'(exp_rd.size()), 0);

    // Fill the FIFO while reads block pops; a push while full is refused.
    for (int c = 0; c < 15; c++) begin
      rd_req = (c < 4); rd_addr = 15'd5;
      if (c < 4) exp_rd.push_back(2'b10);
      if (c < 4) begin
        wr_valid = 1'b1; wr_addr = 15'(20 + c); wr_data = 2'(c);
        exp_wr.push_back({1'b1, 15'(20 + c), 2'(c)});
      end else if (c == 4) begin
        wr_valid = 1'b1; wr_addr = 15'd24; wr_data = 2'd1;
        exp_wr.push_back({1'b1, 15'd24, 2'd1});
      end else if (c == 6) begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 3) chk("wr_ready_3_entries", 32'(wr_ready), 1);
      if (c == 4) chk("wr_ready_full", 32'(wr_ready), 0);
      if (c == 5) chk("wr_ready_after_pop", 32'(wr_ready), 1);
      next_cyc();
    end
    chk("p2_wr_drained", 32'(exp_wr.size()), 0);
    chk("p2_rd_drained", 32'(exp_rd.size()), 0);

    // Clear back bank with reads every other cycle; mid-clear write lands after.
    for (int i = 0; i < FB; i++) exp_wr.push_back({1'b1, 15'(i), 2'b01});
    exp_wr.push_back({1'b1, 15'd9, 2'd3});
    for (int c = 0; c <= CLR_CYC + 10; c++) begin
      clr_start = (c == 0) || (c == 200);
      clr_color = (c == 0) ? 2'b01 : 2'b11;
      rd_req = (c % 2 == 1) && (c < CLR_CYC); rd_addr = 15'd5;
      if (rd_req) exp_rd.push_back(2'b10);
      wr_valid = (c == 100); wr_addr = 15'd9; wr_data = 2'd3;
      @(negedge clk);
      if (c == 1) chk("clr_busy_start", 32'(clr_busy), 1);
      if (c == CLR_CYC) chk("clr_done_early", 32'(clr_done), 0);
      if (c == CLR_CYC) chk("clr_busy_last", 32'(clr_busy), 1);
      if (c == CLR_CYC + 1) chk("clr_done_time", 32'(clr_done), 1);
      if (c == CLR_CYC + 1) chk("clr_busy_end", 32'(clr_busy), 0);
      if (c == CLR_CYC + 2) chk("clr_done_pulse", 32'(clr_done), 0);
      next_cyc();
    end
    clr_start = 1'b0;
    chk("p3_wr_drained", 32'(exp_wr.size()), 0);
    chk("p3_rd_drained", 32'(exp_rd.size()), 0);

    // Swap waits for vblank and an empty FIFO; reads then use bank 1.
    for (int c = 0; c < 20; c++) begin
      frame_end = (c == 0);
      vblank = (c >= 5);
      rd_req = (c == 4) || (c == 5) || (c == 8) || (c == 9);
      rd_addr = (c < 8) ? 15'd5 : ((c == 8) ? 15'd9 : 15'd100);
      if (c == 4 || c == 5) exp_rd.push_back(2'b10);
      if (c == 8) exp_rd.push_back(2'b11);
      if (c == 9) exp_rd.push_back(2'b01);
      wr_valid = (c == 4); wr_addr = 15'd9; wr_data = 2'd3;
      if (c == 4) exp_wr.push_back({1'b1, 15'd9, 2'd3});
      @(negedge clk);
      if (c == 2) chk("swap_no_vblank", 32'(swap), 0);
      if (c == 2) chk("bank_no_vblank", 32'(bank), 0);
      if (c == 5) chk("swap_fifo_held", 32'(swap), 0);
      if (c == 6) chk("swap_fifo_popping", 32'(swap), 0);
      if (c == 7) chk("swap_fire", 32'(swap), 1);
      if (c == 7) chk("bank_before_toggle", 32'(bank), 0);
      if (c == 8) chk("swap_pulse_end", 32'(swap), 0);
      if (c == 8) chk("bank_after_swap", 32'(bank), 1);
      if (c == 9) chk("rd_front_bank_addr", 32'(ram_addr), 32'h8009);
      next_cyc();
    end
    vblank = 1'b0;
    chk("p4_wr_drained", 32'(exp_wr.size()), 0);
    chk("p4_rd_drained", 32'(exp_rd.size()), 0);

    // Two frame_end pulses before vblank give a single swap.
    s0 = swap_cnt;
    for (int c = 0; c < 15; c++) begin
      frame_end = (c == 0) || (c == 2);
      vblank = (c >= 4);
      @(negedge clk);
      next_cyc();
    end
    vblank = 1'b0;
    chk("double_frame_end_swaps", 32'(swap_cnt - s0), 1);
    chk("bank_back_to_0", 32'(bank), 0);

    // Reset mid-clear with a FIFO entry and a pending swap outstanding.
    for (int i = 0; i < 99; i++) exp_wr.push_back({1'b1, 15'(i), 2'b10});
    s0 = swap_cnt;
    for (int c = 0; c <= 100; c++) begin
      clr_start = (c == 0); clr_color = 2'b10;
      wr_valid = (c == 50); wr_addr = 15'd11; wr_data = 2'd2;
      frame_end = (c == 60);
      @(negedge clk);
      if (c == 50) chk("clr_busy_mid", 32'(clr_busy), 1);
      next_cyc();
    end
    rst = 1'b0; clr_start = 1'b0; wr_valid = 1'b0; frame_end = 1'b0;
    @(negedge clk);
    chk("rst_mid_clr_busy", 32'(clr_busy), 0);
    chk("rst_mid_bank", 32'(bank), 0);
    chk("rst_mid_wr_ready", 32'(wr_ready), 1);
    chk("rst_mid_ram_we", 32'(ram_we), 0);
    next_cyc();
    rst = 1'b1; vblank = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      next_cyc();
    end
    vblank = 1'b0;
    chk("rst_dropped_swap", 32'(swap_cnt - s0), 0);
    chk("rst_bank_final", 32'(bank), 0);
    chk("p6_wr_drained", 32'(exp_wr.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
